// File: rtl/mcp_sync_pkg.sv
// Shared constants for the multi-channel bus synchronizer.
// Qualifier modes and the minimum synchronizer depth.
package mcp_sync_pkg;

  localparam int MODE_LEVEL  = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MIN_STAGES  = 2;

endpackage

// File: rtl/mcp_bus_sync_ch.sv
// One synchronizer channel: qualifier flop chain, event detect,
// valid/ready holding register and sticky overflow.
module mcp_bus_sync_ch
  import mcp_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_bus,
  input  logic             bus_en,
  output logic [WIDTH-1:0] sync_bus,
  output logic             sync_valid,
  input  logic             sync_ready,
  output logic             en_pulse,
  output logic             bus_ack,
  output logic             overflow,
  input  logic             ovf_clr
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("STAGES must be at least %0d", MIN_STAGES);
  end

  logic [STAGES-1:0] sync_reg;
  logic              prev_s;
  logic              s;
  logic              evt;
  logic              free;

  assign s       = sync_reg[STAGES-1];
  assign bus_ack = s;
  assign evt     = (TOGGLE_MODE == MODE_TOGGLE) ? (s ^ prev_s)
                                                : (s & ~prev_s);
  // A consumer taking the old word this cycle frees the slot.
  assign free    = ~sync_valid | sync_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= '0;
      prev_s     <= 1'b0;
      sync_bus   <= '0;
      sync_valid <= 1'b0;
      en_pulse   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], bus_en};
      prev_s   <= s;
      en_pulse <= evt & free;
      if (evt & free) begin
        sync_bus   <= async_bus;
        sync_valid <= 1'b1;
      end else if (sync_valid & sync_ready) begin
        sync_valid <= 1'b0;
      end
      // Set has priority over a coincident clear.
      if (evt & ~free) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mcp_bus_sync.sv
// Multi-channel destination-side bus synchronizer.
// Slices the packed buses and instantiates one channel each.
module mcp_bus_sync
  import mcp_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int CHANNELS    = 2,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] async_bus,
  input  logic [CHANNELS-1:0]       bus_en,
  output logic [CHANNELS*WIDTH-1:0] sync_bus,
  output logic [CHANNELS-1:0]       sync_valid,
  input  logic [CHANNELS-1:0]       sync_ready,
  output logic [CHANNELS-1:0]       en_pulse,
  output logic [CHANNELS-1:0]       bus_ack,
  output logic [CHANNELS-1:0]       overflow,
  input  logic [CHANNELS-1:0]       ovf_clr
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mcp_bus_sync_ch #(
      .WIDTH       (WIDTH),
      .STAGES      (STAGES),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .async_bus  (async_bus[c*WIDTH +: WIDTH]),
      .bus_en     (bus_en[c]),
      .sync_bus   (sync_bus[c*WIDTH +: WIDTH]),
      .sync_valid (sync_valid[c]),
      .sync_ready (sync_ready[c]),
      .en_pulse   (en_pulse[c]),
      .bus_ack    (bus_ack[c]),
      .overflow   (overflow[c]),
      .ovf_clr    (ovf_clr[c])
    );
  end

endmodule

// File: tb/tb_mcp_bus_sync.sv
// Scoreboard bench: level 2-stage dual channel, plus
// 3-stage toggle and level single-channel instances.
module tb_mcp_bus_sync;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   pcnt = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t qt[$];
  exp_t ql[$];

  logic [15:0] a_bus = '0;
  logic [1:0]  a_en = '0;
  logic [15:0] a_sbus;
  logic [1:0]  a_valid;
  logic [1:0]  a_ready = 2'b11;
  logic [1:0]  a_pulse;
  logic [1:0]  a_ack;
  logic [1:0]  a_ovf;
  logic [1:0]  a_clr = '0;

  logic [7:0]  t_bus = '0;
  logic        t_en = 1'b0;
  logic [7:0]  t_sbus, l_sbus;
  logic        t_valid, l_valid;
  logic        t_pulse, l_pulse;
  logic        t_ack, l_ack;
  logic        t_ovf, l_ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp_bus_sync #(
    .WIDTH(8), .STAGES(2), .CHANNELS(2), .TOGGLE_MODE(0)
  ) u_a (
    .clk(clk), .rst(rst), .async_bus(a_bus), .bus_en(a_en),
    .sync_bus(a_sbus), .sync_valid(a_valid),
    .sync_ready(a_ready), .en_pulse(a_pulse),
    .bus_ack(a_ack), .overflow(a_ovf), .ovf_clr(a_clr)
  );

  mcp_bus_sync #(
    .WIDTH(8), .STAGES(3), .CHANNELS(1), .TOGGLE_MODE(1)
  ) u_t (
    .clk(clk), .rst(rst), .async_bus(t_bus), .bus_en(t_en),
    .sync_bus(t_sbus), .sync_valid(t_valid),
    .sync_ready(1'b1), .en_pulse(t_pulse),
    .bus_ack(t_ack), .overflow(t_ovf), .ovf_clr(1'b0)
  );

  mcp_bus_sync #(
    .WIDTH(8), .STAGES(3), .CHANNELS(1), .TOGGLE_MODE(0)
  ) u_l (
    .clk(clk), .rst(rst), .async_bus(t_bus), .bus_en(t_en),
    .sync_bus(l_sbus), .sync_valid(l_valid),
    .sync_ready(1'b1), .en_pulse(l_pulse),
    .bus_ack(l_ack), .overflow(l_ovf), .ovf_clr(1'b0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (|a_pulse) pcnt++;
    if (a_pulse[0]) begin
      if (q0.size() == 0) chk("ch0_spurious_pulse", 1, 0);
      else begin
        e = q0.pop_front();
        chk("ch0_data", 32'(a_sbus[7:0]), 32'(e.d));
        chk("ch0_latency", cyc, e.cyc);
        chk("ch0_valid", 32'(a_valid[0]), 1);
      end
    end
    if (a_pulse[1]) begin
      if (q1.size() == 0) chk("ch1_spurious_pulse", 1, 0);
      else begin
        e = q1.pop_front();
        chk("ch1_data", 32'(a_sbus[15:8]), 32'(e.d));
        chk("ch1_latency", cyc, e.cyc);
        chk("ch1_valid", 32'(a_valid[1]), 1);
      end
    end
    if (t_pulse) begin
      if (qt.size() == 0) chk("tgl_spurious_pulse", 1, 0);
      else begin
        e = qt.pop_front();
        chk("tgl_data", 32'(t_sbus), 32'(e.d));
        chk("tgl_latency", cyc, e.cyc);
      end
    end
    if (l_pulse) begin
      if (ql.size() == 0) chk("lvl3_spurious_pulse", 1, 0);
      else begin
        e = ql.pop_front();
        chk("lvl3_data", 32'(l_sbus), 32'(e.d));
        chk("lvl3_latency", cyc, e.cyc);
      end
    end
  end

  task automatic raise(input int ch, input logic [7:0] d,
                       input bit cap, output int n);
    exp_t e;
    @(negedge clk);
    a_bus[ch*8 +: 8] = d;
    a_en[ch] = 1'b1;
    n = cyc;
    e.d = d;
    e.cyc = n + 3;
    if (cap) begin
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic finish_hs(input int ch);
    int t;
    t = 0;
    while (!a_ack[ch] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ack_high", 32'(a_ack[ch]), 1);
    a_en[ch] = 1'b0;
    t = 0;
    while (a_ack[ch] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ack_low", 32'(a_ack[ch]), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_sbus", 32'(a_sbus), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_pulse", 32'(a_pulse), 0);
    chk("rst_ack", 32'(a_ack), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // capture latency and ack latency
    raise(0, 8'hA5, 1, n);
    @(negedge clk);
    chk("ack_edge1", 32'(a_ack[0]), 0);
    @(negedge clk);
    chk("ack_edge2", 32'(a_ack[0]), 1);
    chk("valid_edge2", 32'(a_valid[0]), 0);
    @(negedge clk);
    chk("valid_edge3", 32'(a_valid[0]), 1);
    @(negedge clk);
    chk("pulse_one_cycle", 32'(a_pulse[0]), 0);
    finish_hs(0);

    // backpressure and overflow
    a_ready[0] = 1'b0;
    raise(0, 8'h11, 1, n);
    finish_hs(0);
    raise(0, 8'h22, 0, n);
    finish_hs(0);
    chk("ovf_set", 32'(a_ovf[0]), 1);
    chk("hold_data", 32'(a_sbus[7:0]), 32'h11);
    chk("hold_valid", 32'(a_valid[0]), 1);
    raise(0, 8'h2F, 0, n);
    repeat (2) @(negedge clk);
    a_clr[0] = 1'b1;
    @(negedge clk);
    a_clr[0] = 1'b0;
    chk("ovf_set_wins", 32'(a_ovf[0]), 1);
    chk("hold_data2", 32'(a_sbus[7:0]), 32'h11);
    finish_hs(0);
    @(negedge clk);
    a_clr[0] = 1'b1;
    @(negedge clk);
    a_clr[0] = 1'b0;
    chk("ovf_cleared", 32'(a_ovf[0]), 0);

    // simultaneous accept and capture
    raise(0, 8'h33, 1, n);
    repeat (2) @(negedge clk);
    a_ready[0] = 1'b1;
    @(negedge clk);
    chk("sim_valid", 32'(a_valid[0]), 1);
    chk("sim_ovf", 32'(a_ovf[0]), 0);
    chk("sim_data", 32'(a_sbus[7:0]), 32'h33);
    @(negedge clk);
    chk("drain_valid", 32'(a_valid[0]), 0);
    finish_hs(0);

    // channel independence
    raise(0, 8'h5A, 1, n);
    raise(1, 8'hC3, 1, n);
    finish_hs(0);
    finish_hs(1);
    chk("ind_ch0", 32'(a_sbus[7:0]), 32'h5A);
    chk("ind_ch1", 32'(a_sbus[15:8]), 32'hC3);

    // overflow on ch1 only
    a_ready[1] = 1'b0;
    raise(1, 8'hE1, 1, n);
    finish_hs(1);
    raise(1, 8'hE2, 0, n);
    finish_hs(1);
    chk("ch1_ovf", 32'(a_ovf[1]), 1);
    chk("ch0_no_ovf", 32'(a_ovf[0]), 0);
    chk("ch1_hold", 32'(a_sbus[15:8]), 32'hE1);

    // reset mid-synchronization
    raise(0, 8'h77, 0, n);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_sbus", 32'(a_sbus), 0);
    chk("mrst_valid", 32'(a_valid), 0);
    chk("mrst_pulse", 32'(a_pulse), 0);
    chk("mrst_ack", 32'(a_ack), 0);
    chk("mrst_ovf", 32'(a_ovf), 0);
    a_en = '0;
    a_ready = 2'b11;
    p0 = pcnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_pulse_after_rst", pcnt - p0, 0);
    raise(0, 8'h99, 1, n);
    finish_hs(0);

    // toggle vs level, 3 stages
    @(negedge clk);
    t_bus = 8'h01;
    t_en = 1'b1;
    e.d = 8'h01;
    e.cyc = cyc + 4;
    qt.push_back(e);
    ql.push_back(e);
    repeat (10) @(negedge clk);
    t_bus = 8'h02;
    t_en = 1'b0;
    e.d = 8'h02;
    e.cyc = cyc + 4;
    qt.push_back(e);
    repeat (10) @(negedge clk);
    chk("tgl_data_last", 32'(t_sbus), 32'h02);
    chk("lvl3_data_last", 32'(l_sbus), 32'h01);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("qt_empty", qt.size(), 0);
    chk("ql_empty", ql.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcp_bus_sync.md
# mcp_bus_sync

Multi-channel, destination-side bus synchronizer for the multi-clock system: each channel receives a data bus plus a qualifier from a foreign clock domain, synchronizes the qualifier through a parametrised flop chain, and captures the bus on the detected event. It is a successor to the single-channel enable-pulse synchronizer, adding:
- a toggle-qualifier mode;
- a per-channel valid/ready holding register;
- a 4-phase acknowledge return;
- sticky overflow detection.

It sits on the receiving side of every CDC crossing into the `clk` domain (register file, ALU, UART config paths).

## Interface
Parameters:
- WIDTH, 8, data bits per channel
- STAGES, 2, synchronizer flop count; legal values are 2 and above, and elaboration fails below 2
- CHANNELS, 2, number of independent channels
- TOGGLE_MODE, 0, qualifier mode: 0 = level (a rising edge is the event), 1 = toggle (any edge is the event)

Ports:
- clk  in  1  destination clock; all state is on its rising edge
- rst  in  1  asynchronous, active-high reset
- async_bus  in  CHANNELS*WIDTH  source data, held stable by the sender while its qualifier is asserted or toggled; channel c occupies bits [c*WIDTH +: WIDTH]
- bus_en  in  CHANNELS  per-channel source qualifier (level or toggle per TOGGLE_MODE), asynchronous to clk
- sync_bus  out  CHANNELS*WIDTH  captured data, same channel packing as async_bus
- sync_valid  out  CHANNELS  holding register occupied
- sync_ready  in  CHANNELS  consumer accepts; a transfer occurs when sync_valid and sync_ready are both 1
- en_pulse  out  CHANNELS  one-cycle strobe on each successful capture
- bus_ack  out  CHANNELS  synchronized qualifier level, returned to the source for a 4-phase or toggle handshake
- overflow  out  CHANNELS  sticky; an event was dropped
- ovf_clr  in  CHANNELS  synchronous clear of overflow

## Operation
Each channel is fully independent. Per channel:
- sync_reg[STAGES-1:0] shifts in bus_en on every clk edge. Bit STAGES-1 is the synchronized qualifier `s`.
- prev_s is a register holding `s` from the previous cycle.
- The event is detected combinationally:
  - TOGGLE_MODE=0: event = s & ~prev_s
  - TOGGLE_MODE=1: event = s ^ prev_s
- bus_ack = s, driven directly from the synchronizer output. The source may release or toggle the qualifier again only after it sees bus_ack match.

Holding register, evaluated at each clk edge:
- If event is high and the register is free (sync_valid=0, or sync_valid & sync_ready in the same cycle):
  - sync_bus ← async_bus
  - sync_valid ← 1
  - en_pulse ← 1
- If event is high and sync_valid=1 and sync_ready=0:
  - the data is dropped and sync_bus keeps its old value
  - sync_valid stays 1
  - en_pulse ← 0
  - overflow ← 1
- If there is no event and sync_valid & sync_ready: sync_valid ← 0. sync_bus holds its last value.
- en_pulse is 0 in every cycle that does not perform a capture.

overflow:
- Set by a dropped event.
- Cleared by ovf_clr.
- If set and clear occur in the same cycle, set wins.

Reset (rst=1, asynchronous) drives sync_reg, prev_s, sync_bus, sync_valid, en_pulse and overflow to 0. As a result bus_ack=0.
- Reset asserted mid-transfer discards the held data and any in-flight qualifier.
- After release, a qualifier that is still high is seen as a fresh rising edge in level mode. The source is expected to be reset with the system.

## Timing
- The first clk edge that samples a changed bus_en is edge 1.
- `s` changes after edge STAGES.
- Capture happens at edge STAGES+1. sync_bus, sync_valid and en_pulse all update at that edge, so the latency is STAGES+1 edges.
- bus_ack follows bus_en with STAGES edges of latency.
- The source must hold async_bus stable from qualifier assertion until bus_ack is observed.
- Minimum source event spacing for lossless level mode is 2×(STAGES+1) clk cycles plus the source-side ack synchronization time.

## Structure
- Shared package mcp_sync_pkg holds:
  - the mode constants MODE_LEVEL=0 and MODE_TOGGLE=1
  - MIN_STAGES=2
- Sub-module mcp_bus_sync_ch implements one channel with WIDTH, STAGES and TOGGLE_MODE parameters. The top is a generate loop over CHANNELS that slices the packed buses.

## Test plan
- Capture latency, WIDTH=8, STAGES=2, level mode: bus_en[0] rises with async_bus=0xA5, sync_ready=1.
  - Required: sync_bus[7:0]=0xA5, sync_valid=1 and en_pulse=1 for exactly one cycle, all after edge 3. bus_ack[0]=1 after edge 2.
- Backpressure and overflow: deliver 0x11 with sync_ready=0, then a second event carrying 0x22.
  - Required: sync_bus stays 0x11, overflow=1, no second en_pulse.
  - Then pulse ovf_clr while a third event is dropped: overflow remains 1.
- Simultaneous accept and capture: sync_valid=1 and sync_ready=1 in the same cycle that an event carrying 0x33 arrives.
  - Required: sync_bus=0x33, sync_valid stays 1, en_pulse=1, overflow=0.
- Toggle mode, STAGES=3: toggle bus_en 0→1→0 with data 0x01, then 0x02, spaced 10 cycles apart.
  - Required: two captures, each 4 edges after its toggle. Level mode with the same stimulus yields a single capture.
- Channel independence and reset, CHANNELS=2: events on both channels one cycle apart, then assert rst mid-synchronization.
  - Required: correct per-channel data with no cross-talk. All outputs are 0 within the reset assertion, and there is no en_pulse until a new event arrives after release.
